// File: rtl/control_red_serial_if.sv
// -----------------------------------------------------------------------------
// control_red_serial_if
// Request/result bundle between a requesting datapath and the bit-serial
// magnitude comparator.
//   start   : request, accepted only while the comparator is IDLE or DONE
//   a_in    : operand A (WIDTH bits), sampled when start is accepted
//   b_in    : operand B (WIDTH bits), sampled when start is accepted
//   busy    : high while a comparison is running
//   done    : one-cycle completion pulse
//   a_gt_b  : result flag, A > B
//   a_lt_b  : result flag, A < B
//   a_eq_b  : result flag, A == B
// Modports: master = requester, slave = comparator.
// -----------------------------------------------------------------------------
interface control_red_serial_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;

  modport master (
    output start, a_in, b_in,
    input  busy, done, a_gt_b, a_lt_b, a_eq_b
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, a_gt_b, a_lt_b, a_eq_b
  );
endinterface

// File: rtl/control_red_serial.sv
// -----------------------------------------------------------------------------
// control_red_serial
// Bit-serial unsigned magnitude comparator built around a single
// iterative-network comparison cell. Operands are latched on an accepted
// start, one bit pair per clock is fed MSB first to the cell, and the cell's
// X/Y outputs are fed back through x_q/y_q. The final X/Y give the result.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-low reset
//   bus    : control_red_serial_if.slave (start, a_in, b_in, busy, done,
//            a_gt_b, a_lt_b, a_eq_b)
//
// Optional feature macro: CONTROL_RED_EARLY_STOP_EN
//   Defined   : finish as soon as the cell has decided (X or Y set).
//   Undefined : always scan all WIDTH bits (fixed latency WIDTH+1).
// -----------------------------------------------------------------------------
module control_red_serial #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  control_red_serial_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             x_q;
  logic             y_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  // Comparison cell (celda_tipica_c). X means "A already known greater",
  // Y means "B already known greater"; both are sticky through x/y inputs.
  logic bit_a;
  logic bit_b;
  logic cell_x;
  logic cell_y;
  logic finish_d;

  always_comb begin
    bit_a  = a_sh_q[idx_q];
    bit_b  = b_sh_q[idx_q];
    cell_x = x_q | (~y_q & bit_a & ~bit_b);
    cell_y = y_q | (~cell_x & ~bit_a & bit_b);
  end

`ifdef CONTROL_RED_EARLY_STOP_EN
  // Once the cell has decided, lower bits cannot change the outcome.
  assign finish_d = (idx_q == '0) | cell_x | cell_y;
`else
  assign finish_d = (idx_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      idx_q   <= IW'(WIDTH - 1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a_in;
            b_sh_q  <= bus.b_in;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            idx_q   <= IW'(WIDTH - 1);
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            // Flags are left untouched so the last result stays visible.
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // start is deliberately not looked at here.
          x_q <= cell_x;
          y_q <= cell_y;
          if (finish_d) begin
            gt_q    <= cell_x;
            lt_q    <= cell_y;
            eq_q    <= ~cell_x & ~cell_y;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_gt_b = gt_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_eq_b = eq_q;

endmodule

// File: tb/tb_control_red_serial.sv
// -----------------------------------------------------------------------------
// tb_control_red_serial
// Self-checking bench for control_red_serial (WIDTH=8). Expected results come
// from plain integer comparison of the operands; expected latency from the
// position of the most significant differing bit.
// -----------------------------------------------------------------------------
module tb_control_red_serial;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  control_red_serial_if #(.WIDTH(W)) bus ();

  control_red_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Number of RUN cycles the comparison should take.
  function automatic int exp_runs(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    logic [W-1:0] d;
    r = W;
    d = a ^ b;
`ifdef CONTROL_RED_EARLY_STOP_EN
    if (d != '0) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (d[i]) begin
          r = W - i;   // leading equal bits (W-1-i) plus the deciding bit
          break;
        end
      end
    end
`else
    if (d == '0) r = W;
`endif
    return r;
  endfunction

  function automatic logic [2:0] exp_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    if (int'(a) > int'(b)) return 3'b100;
    if (int'(a) < int'(b)) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] flags();
    return {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
  endfunction

  // One comparison. Cycle c counts from the cycle after the accepting edge.
  //  pre_started : start/operands already presented by the previous call
  //  hold        : keep start high and present na/nb for a back-to-back run
  //  glitch_c    : if nonzero, pulse start with 0x00/0xFF in that cycle
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit pre_started, input bit hold,
                        input logic [W-1:0] na, input logic [W-1:0] nb,
                        input int glitch_c);
    int runs;
    int done_at;
    runs    = exp_runs(a, b);
    done_at = -1;
    if (!pre_started) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
    end
    for (int c = 1; c <= runs + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          bus.a_in = na;
          bus.b_in = nb;
        end else begin
          bus.start = 1'b0;
        end
      end
      if (glitch_c != 0 && c == glitch_c) begin
        bus.start = 1'b1;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'hFF;
      end
      if (glitch_c != 0 && c == glitch_c + 1) bus.start = 1'b0;
      check("busy", 32'(bus.busy), 32'(c <= runs));
      check("done", 32'(bus.done), 32'(c == runs + 1));
      if (bus.done) done_at = c;
    end
    check("done_cycle", 32'(done_at), 32'(runs + 1));
    check("flags", 32'(flags()), 32'(exp_flags(a, b)));
    $display("cmp a=%02h b=%02h done_cycle=%0d flags(gt,lt,eq)=%03b", a, b, done_at, flags());
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    do_cmp(8'h5A, 8'h59, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    do_cmp(8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    do_cmp(8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    // Flags hold in IDLE
    @(negedge clk);
    check("hold_flags", 32'(flags()), 32'b001);
    check("hold_busy", 32'(bus.busy), 32'd0);

    // Back-to-back with start held through DONE
    do_cmp(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 8'h00, 0);
    do_cmp(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 0);

    // start ignored while busy
    do_cmp(8'hC3, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_busy", 32'(bus.busy), 32'd0);
      check("no_extra_done", 32'(bus.done), 32'd0);
    end

    // Reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h80;
    bus.b_in  = 8'h7F;
    @(negedge clk);               // cycle 1
    bus.start = 1'b0;
    @(negedge clk);               // cycle 2
    @(negedge clk);               // cycle 3
    reset = 1'b0;
    @(negedge clk);               // after first reset edge
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_flags", 32'(flags()), 32'd0);
    @(negedge clk);               // second reset edge done
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(bus.done), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    $display("reset mid-run: flags(gt,lt,eq)=%03b", flags());

    // Randomized comparisons, biased toward long common prefixes
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = W'($urandom);
        1: rb = ra;
        default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      do_cmp(ra, rb, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_red_serial.md
# control_red_serial

Sequencer that reuses one iterative-network comparison cell (`celda_tipica_c`) as a bit-serial magnitude comparator for two WIDTH-bit unsigned words. The block latches both operands on a start request and presents one bit pair per clock, MSB first, to the cell. It feeds the cell's X/Y outputs back through registers and reports A>B, A<B or A==B with a done pulse. It sits between a requesting datapath and the combinational cell, replacing a WIDTH-deep cascade of cells with one cell plus state.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the clk rising edge.
- start  in  1  request; accepted only in IDLE or DONE.
- a_in  in  WIDTH  operand A; sampled when start is accepted.
- b_in  in  WIDTH  operand B; sampled when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE.
- a_gt_b  out  1  result flag; registered.
- a_lt_b  out  1  result flag; registered.
- a_eq_b  out  1  result flag; registered.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE, start=1:
  - latch a_in and b_in into shift registers.
  - clear x_r and y_r.
  - set bit index idx=WIDTH-1.
  - clear the three result flags.
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN datapath: the cell is driven with A=a_sh[idx], B=b_sh[idx], x=x_r, y=y_r.
- RUN, every cycle:
  - x_r <= cell X.
  - y_r <= cell Y.
  - the cell computes X = x | (~y & A & ~B) and Y = y | (~X & ~A & B).
- RUN, idx==0: go to DONE. Otherwise idx decrements.
- Entering DONE, the result flags register the final cell outputs:
  - a_gt_b = X.
  - a_lt_b = Y.
  - a_eq_b = ~X & ~Y.
- Exactly one flag is 1 after any completed comparison.
- DONE, start=1: accept the new operands exactly as in IDLE and go to RUN (back-to-back operation).
- DONE, start=0: go to IDLE.
- Result flags hold their value through IDLE until the next accepted start.
- start in RUN is ignored; operands are not re-sampled.
- x_r and y_r are sticky: once either is set, it stays set for the rest of the operation. x_r and y_r are never both 1.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE.
  - busy=0, done=0.
  - a_gt_b=0, a_lt_b=0, a_eq_b=0.
  - x_r=0, y_r=0, idx=WIDTH-1.
- Reset mid-RUN aborts the operation: no done pulse, flags cleared.
- Reset has priority over start in the same cycle.
- Start accepted at edge k:
  - busy=1 from cycle k+1 through k+WIDTH.
  - done=1 in cycle k+WIDTH+1 only.
  - flags valid from cycle k+WIDTH+1.
- Latency is WIDTH+1 cycles from start to done (full mode).
- Throughput is one comparison per WIDTH+1 cycles with start held high.
- busy and done are never high in the same cycle.
- All outputs are registered; there is no combinational path from start, a_in or b_in to any output.

## Configuration
- CONTROL_RED_EARLY_STOP_EN:
  - Defined: in RUN, if cell X or cell Y is 1 on the current bit, go to DONE at that edge regardless of idx. Latency becomes (number of leading equal bits + 1) + 1 cycles. Equal operands still take WIDTH+1 cycles.
  - Undefined: always run all WIDTH bits. Latency is fixed at WIDTH+1 and results are identical.

## Test plan
- Reset behaviour: assert reset=0 for 2 cycles in RUN (WIDTH=8, A=0x80, B=0x7F, start at cycle 0, reset at cycle 3) -> busy=0 and all flags 0 the cycle after reset, no done pulse, state IDLE.
- Greater-than, full mode: A=0x5A, B=0x59 -> done in cycle 9, a_gt_b=1, a_lt_b=0, a_eq_b=0, busy high cycles 1-8.
- Less-than, decided at MSB: A=0x0F, B=0xF0 -> a_lt_b=1. Full mode: done in cycle 9. With CONTROL_RED_EARLY_STOP_EN: done in cycle 2.
- Equality: A=B=0xA5 -> a_eq_b=1, done in cycle 9 in both configurations.
- Back-to-back operation:
  - First comparison: A=0x01, B=0x02; second: A=0xFF, B=0x00.
  - Hold start=1 through DONE.
  - Expected: first done in cycle 9 with a_lt_b=1; busy again from cycle 10; second done in cycle 18 with a_gt_b=1.
- start ignored while busy: pulse start with A=0x00, B=0xFF in cycle 4 of an A=0xC3, B=0xC3 run -> result a_eq_b=1 in cycle 9, no extra operation afterwards.
